emu_ioctl_router: RTL and testbench
===================================

Name: emu_ioctl_router

Overview:
- Parametrised successor to the single-stream ROM download path in the emu top level.
- Takes the hps_io ioctl byte stream and routes ROM bytes into NREGION independent memory regions.
- Packs bytes into BPW-byte words per region and drives a valid/ready write handshake toward each region, throttling the host through ioctl_wait.
- Captures DIP-switch downloads into a register; flags range and overrun errors. Sits between hps_io and the gameboard, replacing direct ioctl fan-out.

Parameters:
- NREGION, 4, number of ROM regions (1..8).
- BPW, 2, bytes per output word (1, 2 or 4).
- ADDR_W, 20, width of region-relative word address.
- REGION_BASE, {27'h30000,27'h20000,27'h10000,27'h0}, packed 27-bit byte base per region, index 0 in LSBs. Ascending, BPW-aligned.
- ROM_END, 27'h40000, exclusive end byte address of the last region.
- ROM_INDEX, 16'd0, ioctl_index value for ROM download.
- DIP_INDEX, 16'd254, ioctl_index value for DIP download.
- DIP_BYTES, 8, DIP register size in bytes.

Ports:
- i_EMU_MCLK  in  1  system clock (CLK40M domain).
- i_EMU_INITRST  in  1  asynchronous active-high reset.
- i_IOCTL_INDEX  in  16  hps_io index.
- i_IOCTL_DOWNLOAD  in  1  download active.
- i_IOCTL_ADDR  in  27  byte address.
- i_IOCTL_DATA  in  8  byte data.
- i_IOCTL_WR  in  1  one-cycle byte strobe.
- o_IOCTL_WAIT  out  1  host stall.
- o_WR_VALID  out  NREGION  one-hot write request.
- i_WR_READY  in  NREGION  per-region accept.
- o_WR_ADDR  out  ADDR_W  word address relative to region base.
- o_WR_DATA  out  8*BPW  packed word, little-endian.
- o_DIP  out  8*DIP_BYTES  DIP register.
- o_ROM_READY  out  1  ROM download complete.
- o_ERR  out  2  sticky errors: [0] out of range, [1] overrun.

Behaviour:
- Reset (async, active-high): all outputs 0 (o_DIP, o_ERR, o_ROM_READY, o_WR_VALID, o_IOCTL_WAIT); state S_IDLE; packer empty.
- Region decode: region i holds addresses in [BASE[i], BASE[i+1]). The last region ends at ROM_END.
  - Word address = (addr - BASE[i]) / BPW.
  - Lane = (addr - BASE[i]) % BPW; the byte goes to bits [8*lane+7 : 8*lane].
- Addresses below BASE[0] or at/above ROM_END: byte dropped, o_ERR[0] set.
- States:
  - S_IDLE: a rising edge of download with index==ROM_INDEX clears o_ROM_READY and the packer, then goes to S_COLLECT.
  - S_COLLECT: each ROM wr stores its byte in the packer.
    - When lane==BPW-1 is written: latch word, addr and region, then go to S_ISSUE.
    - A wr whose word address or region differs from the held partial word flushes the partial word first (unwritten lanes 0) via S_ISSUE; the new byte is then stored.
  - S_ISSUE: o_WR_VALID[region]=1 and o_IOCTL_WAIT=1; data and addr held stable.
    - On i_WR_READY[region]=1, drop valid in the next cycle.
    - Then return to S_COLLECT, or go to S_FLUSH if download has fallen.
  - S_FLUSH: entered on download falling edge. A pending partial word is issued through S_ISSUE; otherwise go to S_DONE.
  - S_DONE: o_ROM_READY=1 (held until the next ROM download rises); o_IOCTL_WAIT=0; go to S_IDLE.
- Wait timing: o_IOCTL_WAIT is registered.
  - Rises the cycle after the word-completing wr.
  - Falls the cycle after the accepting ready.
  - Minimum stall is 2 cycles even if ready is already high.
- Overrun: an i_IOCTL_WR during S_ISSUE drops the byte and sets o_ERR[1]. Valid, data and addr stay unchanged.
- DIP: a wr with index==DIP_INDEX and addr<DIP_BYTES writes o_DIP byte[addr] in the next cycle. No wait, no state change. Addresses ≥ DIP_BYTES are ignored. o_DIP is retained across ROM downloads.
- Other indices: ignored.
- Reset mid-download: after release, bytes are ignored until download deasserts and reasserts (an armed flag is set on download low).
- Simultaneous download fall and wr on the same cycle: the byte is taken, then the flush proceeds.
- o_ERR bits clear only on reset.

Decomposition:
- Package emu_ioctl_pkg:
  - ROM/DIP index constants.
  - State enum (S_IDLE, S_COLLECT, S_ISSUE, S_FLUSH, S_DONE).
  - Function region_decode(addr) returning {hit, region, offset}.
- Sub-module emu_ioctl_packer: byte lane store, held word address and region, partial/full flags, clear and flush.

Test Plan (NREGION=2, BPW=2, BASE={0x8000,0x0}, ROM_END=0x10000):
- ROM bytes 0x11@0x0000, 0x22@0x0001, ready tied high -> o_WR_VALID=2'b01, addr 0, data 16'h2211; o_IOCTL_WAIT high exactly 2 cycles.
- Bytes 0xAA@0x8004, 0xBB@0x8005 with i_WR_READY[1] low 5 cycles -> valid[1] and wait held 5+ cycles, addr 2, data 16'hBBAA; accepted once.
- Odd-length stream ending with 0x33@0x0002, then download falls -> flush word addr 1, data 16'h0033; then o_ROM_READY=1.
- Byte @0x10000 plus a wr during S_ISSUE -> o_ERR=2'b11; no extra o_WR_VALID pulse.
- DIP index 254, bytes 0x5A@0, 0xC3@7, 0xFF@8 -> o_DIP[7:0]=0x5A, o_DIP[63:56]=0xC3; nothing else changes; no wait.
- Reset asserted mid-word, download held high -> all outputs 0; further bytes ignored until download toggles low→high.

Source files
------------

// File: rtl/emu_ioctl_pkg.sv
// emu_ioctl_pkg: shared constants, FSM states and region decode for the ioctl router
package emu_ioctl_pkg;
  localparam logic [15:0] ROM_IDX = 16'd0;
  localparam logic [15:0] DIP_IDX = 16'd254;
  localparam int MAX_REGION = 8;
  typedef enum logic [2:0] {S_IDLE, S_COLLECT, S_ISSUE, S_FLUSH, S_DONE} state_t;
  typedef struct packed {
    logic        hit;
    logic [2:0]  region;
    logic [26:0] offset;
  } dec_t;
  // Bases are ascending, so the last base at or below addr owns it.
  function automatic dec_t region_decode(input logic [26:0] addr, input logic [27*MAX_REGION-1:0] base,
                                         input int n, input logic [26:0] rom_end);
    dec_t d;
    d = '0;
    for (int i = 0; i < MAX_REGION; i++)
      if (i < n && addr >= base[27*i +: 27] && addr < rom_end) begin
        d.hit    = 1'b1;
        d.region = 3'(i);
        d.offset = addr - base[27*i +: 27];
      end
    return d;
  endfunction
endpackage

// File: rtl/emu_ioctl_packer.sv
// emu_ioctl_packer: byte-lane store holding one partial word with its address and region
module emu_ioctl_packer #(
  parameter int BPW    = 2,
  parameter int ADDR_W = 20
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              st_i,
  input  logic [1:0]        lane_i,
  input  logic [7:0]        byte_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        region_i,
  output logic [8*BPW-1:0]  data_o,
  output logic [8*BPW-1:0]  merged_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [2:0]        region_o,
  output logic              partial_o,
  output logic              full_o
);
  logic [8*BPW-1:0] data_q, mask, ins, base;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0] region_q;
  logic partial_q, full_q;
  assign mask = (8*BPW)'(8'hFF) << (8 * lane_i);
  assign ins = (8*BPW)'(byte_i) << (8 * lane_i);
  assign base = clr_i ? '0 : data_q;
  assign merged_o = (data_q & ~mask) | ins;
  assign data_o = data_q;
  assign addr_o = addr_q;
  assign region_o = region_q;
  assign partial_o = partial_q;
  assign full_o = full_q;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      data_q    <= '0;
      addr_q    <= '0;
      region_q  <= '0;
      partial_q <= 1'b0;
      full_q    <= 1'b0;
    end else if (st_i) begin
      data_q    <= (base & ~mask) | ins;
      addr_q    <= addr_i;
      region_q  <= region_i;
      partial_q <= 1'b1;
      full_q    <= (!clr_i && full_q) || lane_i == 2'(BPW - 1);
    end else if (clr_i) begin
      data_q    <= '0;
      partial_q <= 1'b0;
      full_q    <= 1'b0;
    end
endmodule

// File: rtl/emu_ioctl_router.sv
// emu_ioctl_router: routes hps_io ROM bytes into per-region packed word writes and captures DIP bytes
module emu_ioctl_router import emu_ioctl_pkg::*; #(
  parameter int                     NREGION     = 4,
  parameter int                     BPW         = 2,
  parameter int                     ADDR_W      = 20,
  parameter logic [27*NREGION-1:0]  REGION_BASE = {27'h30000, 27'h20000, 27'h10000, 27'h0},
  parameter logic [26:0]            ROM_END     = 27'h40000,
  parameter logic [15:0]            ROM_INDEX   = ROM_IDX,
  parameter logic [15:0]            DIP_INDEX   = DIP_IDX,
  parameter int                     DIP_BYTES   = 8
) (
  input  logic                   i_EMU_MCLK,
  input  logic                   i_EMU_INITRST,
  input  logic [15:0]            i_IOCTL_INDEX,
  input  logic                   i_IOCTL_DOWNLOAD,
  input  logic [26:0]            i_IOCTL_ADDR,
  input  logic [7:0]             i_IOCTL_DATA,
  input  logic                   i_IOCTL_WR,
  output logic                   o_IOCTL_WAIT,
  output logic [NREGION-1:0]     o_WR_VALID,
  input  logic [NREGION-1:0]     i_WR_READY,
  output logic [ADDR_W-1:0]      o_WR_ADDR,
  output logic [8*BPW-1:0]       o_WR_DATA,
  output logic [8*DIP_BYTES-1:0] o_DIP,
  output logic                   o_ROM_READY,
  output logic [1:0]             o_ERR
);
  localparam logic [27*MAX_REGION-1:0] BASE_ALL = (27*MAX_REGION)'(REGION_BASE);
  state_t state_q, state_d;
  logic wait_q, wait_d, rdy_q, rdy_d, dl_q, armed_q;
  logic [NREGION-1:0] valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, ld_addr, waddr, pk_addr;
  logic [8*BPW-1:0] data_q, ld_data, pk_data, pk_nxt;
  logic [2:0] ld_reg, pk_reg;
  logic [1:0] err_q, err_d, lane;
  logic [8*DIP_BYTES-1:0] dip_q;
  logic ld, pk_clr, pk_st, pk_part, pk_full, rom_wr, rise, mism, last;
  dec_t dec;
  assign dec = region_decode(i_IOCTL_ADDR, BASE_ALL, NREGION, ROM_END);
  assign waddr = ADDR_W'(dec.offset / 27'(BPW));
  assign lane = 2'(dec.offset % 27'(BPW));
  assign last = lane == 2'(BPW - 1);
  assign rom_wr = i_IOCTL_WR && i_IOCTL_INDEX == ROM_INDEX;
  // armed_q blocks a download that was already high when reset released
  assign rise = armed_q && i_IOCTL_DOWNLOAD && !dl_q && i_IOCTL_INDEX == ROM_INDEX;
  assign mism = pk_part && (waddr != pk_addr || dec.region != pk_reg);
  emu_ioctl_packer #(.BPW(BPW), .ADDR_W(ADDR_W)) u_packer (
    .clk_i(i_EMU_MCLK), .rst_i(i_EMU_INITRST), .clr_i(pk_clr), .st_i(pk_st),
    .lane_i(lane), .byte_i(i_IOCTL_DATA), .addr_i(waddr), .region_i(dec.region),
    .data_o(pk_data), .merged_o(pk_nxt), .addr_o(pk_addr), .region_o(pk_reg),
    .partial_o(pk_part), .full_o(pk_full)
  );
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    valid_d = valid_q;
    err_d   = err_q;
    rdy_d   = rdy_q;
    ld      = 1'b0;
    pk_clr  = 1'b0;
    pk_st   = 1'b0;
    ld_data = pk_data;
    ld_addr = pk_addr;
    ld_reg  = pk_reg;
    case (state_q)
      S_IDLE: if (rise) begin
        rdy_d   = 1'b0;
        pk_clr  = 1'b1;
        state_d = S_COLLECT;
      end
      S_COLLECT: begin
        state_d = i_IOCTL_DOWNLOAD ? S_COLLECT : S_FLUSH;
        // A mismatching byte evicts the held partial word and becomes the new partial
        if (rom_wr && !dec.hit) err_d[0] = 1'b1;
        else if (rom_wr && (mism || last)) begin
          ld      = 1'b1;
          pk_clr  = 1'b1;
          pk_st   = mism;
          ld_data = mism ? pk_data : pk_nxt;
          ld_addr = mism ? pk_addr : waddr;
          ld_reg  = mism ? pk_reg : dec.region;
        end else if (rom_wr) pk_st = 1'b1;
      end
      S_ISSUE: begin
        if (rom_wr) err_d[1] = 1'b1;
        // valid_q low here means the word was accepted last cycle
        if (|valid_q) valid_d = |(valid_q & i_WR_READY) ? '0 : valid_q;
        else if (pk_full) begin
          ld     = 1'b1;
          pk_clr = 1'b1;
        end else begin
          wait_d  = 1'b0;
          state_d = i_IOCTL_DOWNLOAD ? S_COLLECT : S_FLUSH;
        end
      end
      S_FLUSH: if (pk_part) begin
        ld     = 1'b1;
        pk_clr = 1'b1;
      end else state_d = S_DONE;
      S_DONE: begin
        rdy_d   = 1'b1;
        wait_d  = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (ld) begin
      valid_d = NREGION'(1) << ld_reg;
      wait_d  = 1'b1;
      state_d = S_ISSUE;
    end
  end
  always_ff @(posedge i_EMU_MCLK or posedge i_EMU_INITRST)
    if (i_EMU_INITRST) begin
      state_q <= S_IDLE;
      wait_q  <= 1'b0;
      valid_q <= '0;
      err_q   <= '0;
      rdy_q   <= 1'b0;
      dl_q    <= 1'b0;
      armed_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      dip_q   <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      dl_q    <= i_IOCTL_DOWNLOAD;
      armed_q <= armed_q | ~i_IOCTL_DOWNLOAD;
      if (ld) begin
        addr_q <= ld_addr;
        data_q <= ld_data;
      end
      for (int i = 0; i < DIP_BYTES; i++)
        if (i_IOCTL_WR && i_IOCTL_INDEX == DIP_INDEX && i_IOCTL_ADDR == 27'(i)) dip_q[8*i +: 8] <= i_IOCTL_DATA;
    end
  assign o_IOCTL_WAIT = wait_q;
  assign o_WR_VALID = valid_q;
  assign o_WR_ADDR = addr_q;
  assign o_WR_DATA = data_q;
  assign o_DIP = dip_q;
  assign o_ROM_READY = rdy_q;
  assign o_ERR = err_q;
endmodule

// File: tb/tb_emu_ioctl_router.sv
// tb_emu_ioctl_router: directed scoreboard bench for the ioctl router (2 regions, 16-bit words)
module tb_emu_ioctl_router;
  typedef struct packed {
    logic [1:0]  v;
    logic [19:0] a;
    logic [15:0] d;
  } exp_t;
  logic clk, rst, download, wr_s;
  logic [15:0] index;
  logic [26:0] addr;
  logic [7:0] data;
  logic [1:0] ready;
  logic wait_o, rom_ready;
  logic [1:0] valid, err;
  logic [19:0] wr_addr;
  logic [15:0] wr_data;
  logic [63:0] dip;
  int checks = 0, failures = 0, hs_cnt = 0, run = 0, last_wait = 0, h0;
  exp_t q[$];
  exp_t e;
  emu_ioctl_router #(
    .NREGION(2), .BPW(2), .ADDR_W(20), .REGION_BASE({27'h8000, 27'h0}), .ROM_END(27'h10000)
  ) dut (
    .i_EMU_MCLK(clk), .i_EMU_INITRST(rst), .i_IOCTL_INDEX(index), .i_IOCTL_DOWNLOAD(download),
    .i_IOCTL_ADDR(addr), .i_IOCTL_DATA(data), .i_IOCTL_WR(wr_s), .o_IOCTL_WAIT(wait_o),
    .o_WR_VALID(valid), .i_WR_READY(ready), .o_WR_ADDR(wr_addr), .o_WR_DATA(wr_data),
    .o_DIP(dip), .o_ROM_READY(rom_ready), .o_ERR(err)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  always @(negedge clk) begin
    if (|(valid & ready)) begin
      hs_cnt++;
      checks++;
      assert (q.size() != 0) else begin
        failures++;
        $error("FAIL extra_write observed valid=%b addr=%0h data=%0h expected=none", valid, wr_addr, wr_data);
      end
      if (q.size() != 0) begin
        e = q.pop_front();
        checks++;
        assert ({valid, wr_addr, wr_data} === e) else begin
          failures++;
          $error("FAIL sb_write observed v=%b a=%0h d=%0h expected v=%b a=%0h d=%0h",
                 valid, wr_addr, wr_data, e.v, e.a, e.d);
        end
      end
    end
    if (wait_o) run++;
    else begin
      if (run != 0) last_wait = run;
      run = 0;
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [15:0] idx, input logic [26:0] a, input logic [7:0] d);
    index = idx;
    addr = a;
    data = d;
    wr_s = 1'b1;
    tick(1);
    wr_s = 1'b0;
  endtask
  task automatic push(input logic [1:0] v, input logic [19:0] a, input logic [15:0] d);
    q.push_back('{v: v, a: a, d: d});
  endtask
  task automatic wait_clear(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (!wait_o) break;
    end
    chk(tag, 64'(wait_o), 0);
  endtask
  task automatic wait_rdy(input string tag);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1;
      if (rom_ready) break;
    end
    chk(tag, 64'(rom_ready), 1);
  endtask
  initial begin
    rst = 1'b1; download = 1'b0; wr_s = 1'b0; index = 16'd0; addr = '0; data = '0; ready = 2'b11;
    tick(3);
    chk("rst_wait", 64'(wait_o), 0);
    chk("rst_valid", 64'(valid), 0);
    chk("rst_err", 64'(err), 0);
    chk("rst_rdy", 64'(rom_ready), 0);
    chk("rst_dip", dip, 0);
    rst = 1'b0;
    tick(2);
    download = 1'b1;
    tick(2);
    push(2'b01, 20'h0, 16'h2211);
    wr(16'd0, 27'h0, 8'h11);
    wr(16'd0, 27'h1, 8'h22);
    wait_clear("t1_wait_clear");
    chk("t1_wait_len", 64'(last_wait), 2);
    ready = 2'b01;
    h0 = hs_cnt;
    push(2'b10, 20'h2, 16'hBBAA);
    wr(16'd0, 27'h8004, 8'hAA);
    wr(16'd0, 27'h8005, 8'hBB);
    tick(5);
    chk("t2_hold_valid", 64'(valid), 2'b10);
    chk("t2_hold_wait", 64'(wait_o), 1);
    chk("t2_hold_addr", 64'(wr_addr), 2);
    chk("t2_hold_data", 64'(wr_data), 16'hBBAA);
    ready = 2'b11;
    wait_clear("t2_wait_clear");
    chk("t2_wait_ge6", 64'(last_wait >= 6), 1);
    chk("t2_once", 64'(hs_cnt - h0), 1);
    wr(16'd0, 27'h6, 8'h44);
    push(2'b01, 20'h3, 16'h0044);
    wr(16'd0, 27'h8000, 8'h55);
    wait_clear("t3_evict0_clear");
    push(2'b10, 20'h0, 16'h0055);
    wr(16'd0, 27'h2, 8'h33);
    wait_clear("t3_evict1_clear");
    chk("t3_rdy_before", 64'(rom_ready), 0);
    push(2'b01, 20'h1, 16'h0033);
    download = 1'b0;
    wait_rdy("t3_rom_ready");
    tick(2);
    download = 1'b1;
    tick(2);
    chk("t4_rdy_cleared", 64'(rom_ready), 0);
    wr(16'd0, 27'h10000, 8'hEE);
    chk("t4_err_range", 64'(err), 2'b01);
    ready = 2'b10;
    h0 = hs_cnt;
    push(2'b01, 20'h0, 16'h0201);
    wr(16'd0, 27'h0, 8'h01);
    wr(16'd0, 27'h1, 8'h02);
    tick(1);
    wr(16'd0, 27'h4, 8'h99);
    chk("t4_err_both", 64'(err), 2'b11);
    chk("t4_valid_kept", 64'(valid), 2'b01);
    chk("t4_data_kept", 64'(wr_data), 16'h0201);
    chk("t4_addr_kept", 64'(wr_addr), 0);
    ready = 2'b11;
    wait_clear("t4_wait_clear");
    download = 1'b0;
    wait_rdy("t4_rom_ready");
    chk("t4_once", 64'(hs_cnt - h0), 1);
    index = 16'd254;
    download = 1'b1;
    tick(1);
    wr(16'd254, 27'h0, 8'h5A);
    chk("t5_no_wait", 64'(wait_o), 0);
    wr(16'd254, 27'h7, 8'hC3);
    wr(16'd254, 27'h8, 8'hFF);
    chk("t5_dip", dip, 64'hC300_0000_0000_005A);
    chk("t5_err_kept", 64'(err), 2'b11);
    chk("t5_rdy_kept", 64'(rom_ready), 1);
    chk("t5_no_valid", 64'(valid), 0);
    download = 1'b0;
    index = 16'd0;
    tick(2);
    download = 1'b1;
    tick(2);
    wr(16'd0, 27'h0, 8'h77);
    rst = 1'b1;
    #1;
    chk("t6_rst_wait", 64'(wait_o), 0);
    chk("t6_rst_valid", 64'(valid), 0);
    chk("t6_rst_err", 64'(err), 0);
    chk("t6_rst_rdy", 64'(rom_ready), 0);
    chk("t6_rst_dip", dip, 0);
    tick(2);
    rst = 1'b0;
    h0 = hs_cnt;
    wr(16'd0, 27'h0, 8'h10);
    wr(16'd0, 27'h1, 8'h20);
    tick(3);
    chk("t6_ignored_valid", 64'(valid), 0);
    chk("t6_ignored_wait", 64'(wait_o), 0);
    chk("t6_ignored_hs", 64'(hs_cnt - h0), 0);
    download = 1'b0;
    tick(2);
    download = 1'b1;
    tick(2);
    push(2'b01, 20'h0, 16'h2010);
    wr(16'd0, 27'h0, 8'h10);
    wr(16'd0, 27'h1, 8'h20);
    wait_clear("t6_wait_clear");
    chk("t6_rearmed_hs", 64'(hs_cnt - h0), 1);
    download = 1'b0;
    wait_rdy("t6_rom_ready");
    tick(2);
    chk("sb_empty", 64'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
